// File: rtl/i2c_eeprom_pkg.sv
// Purpose     : shared types and constants for the i2c_eeprom_slave block.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
package i2c_eeprom_pkg;

  // Byte-level protocol states of the EEPROM slave.
  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    WORDADDR,
    ACK_WORD,
    WR_BYTE,
    ACK_WR,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int RW_BIT   = 0;  // R/W flag position in the device-address byte
  localparam int BYTE_LEN = 8;

  localparam logic [3:0] BIT_LAST = 4'(BYTE_LEN - 1);
  localparam logic [3:0] BIT_FULL = 4'(BYTE_LEN);

endpackage

// File: rtl/i2c_line_sync.sv
// Purpose     : synchronizes SCL/SDA into clk and flags SCL edges and START/STOP.
// Latency     : SYNC_STAGES + 1 clk from pin change to event pulse.
// Backpressure: none; events are single-cycle pulses.
// Ports: clk, rst (async, active-high); scl_line, sda_line (raw bus levels);
//        sda (synchronized SDA level); scl_rise, scl_fall, start_det, stop_det.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_line};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_line};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl & ~scl_hist;
  assign scl_fall  = ~scl &  scl_hist;
  // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples.
  assign start_det = scl & scl_hist &  sda_hist & ~sda;
  assign stop_det  = scl & scl_hist & ~sda_hist &  sda;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// Purpose     : I2C slave modelling a 24C02-class EEPROM (dev addr, word addr, auto-increment).
// Latency     : SDA drive changes SYNC_STAGES+2 clk after the SCL falling edge on the pin.
// Backpressure: none; SCL is never stretched, SCL phases must be >= 4 clk_i cycles.
// Ports: clk_i, rst_i (async, active-high); scl_i, sda_i (bus levels);
//        wp_i (write protect, only with I2C_EEPROM_WP_EN defined);
//        sda_oe_o (1 = pull SDA low); busy_o (between START and STOP).
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'b1010000,
  parameter int         MEM_DEPTH   = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
`ifdef I2C_EEPROM_WP_EN
  input  logic wp_i,
`endif
  output logic sda_oe_o,
  output logic busy_o
);

  localparam int              AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0]   PTR_MAX = AW'(MEM_DEPTH - 1);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk_i),
    .rst       (rst_i),
    .scl_line  (scl_i),
    .sda_line  (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  logic wp_act;
`ifdef I2C_EEPROM_WP_EN
  assign wp_act = wp_i;
`else
  assign wp_act = 1'b0;
`endif

  // Contents survive reset; blank EEPROM reads as all ones.
  logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          nack_q, nack_d;
  logic          mem_we;
  logic [7:0]    wr_byte, rd_byte;
  logic          rx_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'd0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[ptr_q] <= wr_byte;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    mem_we    = 1'b0;
    wr_byte   = {shreg_q[6:0], sda};
    rd_byte   = mem[ptr_q];
    ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    rx_state  = (state_q == DEVADDR) || (state_q == WORDADDR) || (state_q == WR_BYTE);

    if (start_det) begin
      // Also a repeated START: any partial byte is dropped here.
      state_d   = DEVADDR;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      if (rx_state && scl_rise && bit_cnt_q != BIT_FULL) begin
        shreg_d   = wr_byte;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end

      unique case (state_q)
        DEVADDR: begin
          if (scl_fall && bit_cnt_q == BIT_FULL) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d = ACK_DEV;
              oe_d    = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // shreg still holds the address byte here, so R/W is read straight from it.
        ACK_DEV: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shreg_q[RW_BIT]) begin
              state_d = RD_BYTE;
              shreg_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = WORDADDR;
              oe_d    = 1'b0;
            end
          end
        end
        WORDADDR: begin
          if (scl_fall && bit_cnt_q == BIT_FULL) begin
            ptr_d   = shreg_q[AW-1:0];
            state_d = ACK_WORD;
            oe_d    = 1'b1;
          end
        end
        ACK_WORD, ACK_WR: begin
          if (scl_fall) begin
            state_d   = WR_BYTE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
          end
        end
        WR_BYTE: begin
          // Commit on the 8th rising edge; protected writes still advance the pointer.
          if (scl_rise && bit_cnt_q == BIT_LAST) begin
            mem_we = ~wp_act;
            ptr_d  = ptr_inc;
          end
          if (scl_fall && bit_cnt_q == BIT_FULL) begin
            state_d = ACK_WR;
            oe_d    = ~wp_act;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) ptr_d = ptr_inc;
          end
          if (scl_fall) begin
            if (bit_cnt_q == BIT_FULL) begin
              state_d = RD_ACK;
              oe_d    = 1'b0;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
              oe_d    = ~shreg_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) nack_d = sda;
          if (scl_fall) begin
            if (nack_q) begin
              state_d = IGNORE;
              oe_d    = 1'b0;
            end else begin
              state_d   = RD_BYTE;
              bit_cnt_d = 4'd0;
              shreg_d   = rd_byte;
              oe_d      = ~rd_byte[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o = oe_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Purpose     : directed bus-level bench for i2c_eeprom_slave (I2C master model + checks).
// Latency     : n/a.
// Backpressure: n/a.
module tb_i2c_eeprom_slave;

  localparam int Q = 60;  // quarter SCL period: 6 clk, so each SCL phase is 12 clk

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl   = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe;
  logic busy;
`ifdef I2C_EEPROM_WP_EN
  logic wp = 1'b0;
`endif

  wire sda_line = sda_m & ~sda_oe;

  int checks   = 0;
  int failures = 0;
  int oe_cnt   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (sda_oe) oe_cnt++;

  i2c_eeprom_slave dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl),
    .sda_i    (sda_line),
`ifdef I2C_EEPROM_WP_EN
    .wp_i     (wp),
`endif
    .sda_oe_o (sda_oe),
    .busy_o   (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic v);
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    v     = sda_line; #Q;
    scl   = 1'b0; #Q;
  endtask

  // ack_n = 0 when the slave acknowledged.
  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         oe_before;

    repeat (3) @(posedge clk);
    #2;
    check_eq("reset_oe", 32'(sda_oe), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #Q;

    // Write 0x5A,0xC3 at 0x10.
    bus_start();
    write_byte(8'hA0, a); check_eq("wr_dev_ack", 32'(a), 32'd0);
    write_byte(8'h10, a); check_eq("wr_word_ack", 32'(a), 32'd0);
    write_byte(8'h5A, a); check_eq("wr_data0_ack", 32'(a), 32'd0);
    write_byte(8'hC3, a); check_eq("wr_data1_ack", 32'(a), 32'd0);
    check_eq("busy_in_txn", 32'(busy), 32'd1);
    bus_stop();
    check_eq("busy_after_stop", 32'(busy), 32'd0);

    // Random read of two bytes from 0x10.
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h10, a);
    bus_start();
    write_byte(8'hA1, a); check_eq("rd_dev_ack", 32'(a), 32'd0);
    read_byte(1'b0, d);   check_eq("rd_byte0", 32'(d), 32'h5A);
    read_byte(1'b1, d);   check_eq("rd_byte1", 32'(d), 32'hC3);
    bus_stop();

    // Reset while the slave drives the first (zero) bit of 0x5A.
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h10, a);
    bus_start();
    write_byte(8'hA1, a);
    check_eq("rd_drive_low", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_oe", 32'(sda_oe), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    scl   = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #Q;
    bus_start();
    write_byte(8'hA0, a); check_eq("post_rst_dev_ack", 32'(a), 32'd0);
    write_byte(8'h10, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, d);   check_eq("post_rst_read", 32'(d), 32'h5A);
    bus_stop();

    // Wrong device address: no ACK, SDA never driven, busy until STOP.
    oe_before = oe_cnt;
    bus_start();
    write_byte(8'hA2, a); check_eq("wrong_dev_nack", 32'(a), 32'd1);
    write_byte(8'h00, a); check_eq("wrong_dev_data_nack", 32'(a), 32'd1);
    check_eq("wrong_dev_busy", 32'(busy), 32'd1);
    bus_stop();
    check_eq("wrong_dev_busy_stop", 32'(busy), 32'd0);
    check_eq("wrong_dev_no_drive", 32'(oe_cnt - oe_before), 32'd0);

    // Pointer wrap: 0x11 at 0xFF, 0x22 at 0x00, then current-address read hits 0x01.
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a); check_eq("wrap_data0_ack", 32'(a), 32'd0);
    write_byte(8'h22, a); check_eq("wrap_data1_ack", 32'(a), 32'd0);
    bus_stop();
    bus_start();
    write_byte(8'hA1, a); check_eq("cur_rd_ack", 32'(a), 32'd0);
    read_byte(1'b1, d);   check_eq("cur_rd_0x01", 32'(d), 32'hFF);
    bus_stop();
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'hFF, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b0, d);   check_eq("wrap_rd_0xff", 32'(d), 32'h11);
    read_byte(1'b1, d);   check_eq("wrap_rd_0x00", 32'(d), 32'h22);
    bus_stop();

    // Repeated START four bits into a data byte: the byte is dropped.
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h30, a);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    bus_start();
    write_byte(8'hA0, a); check_eq("restart_dev_ack", 32'(a), 32'd0);
    write_byte(8'h30, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, d);   check_eq("partial_discard", 32'(d), 32'hFF);
    bus_stop();

`ifdef I2C_EEPROM_WP_EN
    // Write protect: addresses ACKed, data NACKed, memory unchanged.
    wp = 1'b1;
    bus_start();
    write_byte(8'hA0, a); check_eq("wp_dev_ack", 32'(a), 32'd0);
    write_byte(8'h20, a); check_eq("wp_word_ack", 32'(a), 32'd0);
    write_byte(8'h77, a); check_eq("wp_data_nack", 32'(a), 32'd1);
    bus_stop();
    wp = 1'b0;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h20, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, d);   check_eq("wp_mem_unchanged", 32'(d), 32'hFF);
    bus_stop();
`endif

    #Q;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C slave modelling a 24C02-class serial EEPROM: a 7-bit device address, a 1-byte word address, and a byte-wide memory with auto-incrementing pointer.
- Sits on the board-level I2C bus behind the pad buffer, attached to the SoC I2C master's open-drain SCL/SDA lines.
- Oversamples SCL/SDA with the system clock; drives SDA only as open-drain (low or released).

Parameters:
- DEV_ADDR, 7'b1010000, 7-bit slave address matched on the first byte after START.
- MEM_DEPTH, 256, number of bytes; word address width = clog2(MEM_DEPTH), max 8.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (min 2).

Ports:
- clk_i, in, 1, system clock; SCL/SDA are sampled on its rising edge.
- rst_i, in, 1, asynchronous, active-high reset.
- scl_i, in, 1, SCL line level (slave never stretches the clock).
- sda_i, in, 1, SDA line level.
- sda_oe_o, in→out, 1, output; 1 = pull SDA low, 0 = release.
- busy_o, out, 1, high between a detected START and the next STOP.

Behaviour:
- Inputs pass through SYNC_STAGES flops plus one history flop. Edge detection uses the synchronized values.
- START condition: SDA falls while SCL is high. Detected in any state, including as a repeated START. Result: bit counter cleared, state DEVADDR, sda_oe_o released.
- STOP condition: SDA rises while SCL is high. Detected in any state. Result: state IDLE, sda_oe_o=0, busy_o=0.
- Data bits are sampled on SCL rising edges, MSB first. sda_oe_o changes only on the clk cycle after an SCL falling edge.
- States and transitions:
  - IDLE waits for START.
  - DEVADDR shifts 8 bits. If bits[7:1]==DEV_ADDR, go to ACK_DEV. Otherwise go to IGNORE, which waits for START/STOP and never drives.
  - ACK_DEV drives ACK (sda_oe_o=1) from the falling edge after bit 8 to the falling edge after bit 9. Then, if R/W=0, go to WORDADDR; if R/W=1, go to RD_BYTE.
  - WORDADDR receives 8 bits, loads the pointer (upper bits ignored when MEM_DEPTH<256), then ACK to WR_BYTE.
  - WR_BYTE receives 8 bits. On the 8th SCL rising edge, writes mem[ptr]<=byte and increments ptr. Then ACK back to WR_BYTE.
  - RD_BYTE loads mem[ptr] and drives sda_oe_o=~bit (MSB first) starting at the falling edge ending the ACK. ptr increments after the 8th bit. On the 9th bit, samples the master's ACK: SDA=0 → next byte; SDA=1 (NACK) → release, go to IGNORE.
- Pointer wraps from MEM_DEPTH-1 to 0, for both reads and writes. No page-boundary wrap.
- Random read: write dev+word address, repeated START, dev+R. Current-address read: dev+R directly after START, using the retained pointer.
- Reset: state IDLE, sda_oe_o=0, busy_o=0, ptr=0. Memory contents are not reset and power up as 8'hFF (array initializer).
- Timing requirement: SCL high and low phases must each be ≥4 clk_i cycles. Faster SCL is unsupported.
- A START/STOP that interrupts a byte discards the partial byte. No memory write occurs for that byte.

Optional Feature:
- Macro I2C_EEPROM_WP_EN.
- When defined: adds input port wp_i (1 bit). While wp_i=1, data bytes in WR_BYTE are NACKed (sda_oe_o stays 0), memory is unchanged, and ptr still increments. Device-address and word-address bytes are still ACKed.
- When undefined: no wp_i port; all writes are accepted.

Decomposition:
- Package i2c_eeprom_pkg holds:
  - the state enum (IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WORD, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK, IGNORE);
  - localparams for the R/W bit position and the byte length of 8.
- One sub-module, i2c_line_sync: synchronizer plus edge detector producing scl_rise, scl_fall, start_det and stop_det.

Test Plan:
- Reset asserted mid-read while SDA is driven low → sda_oe_o=0 and busy_o=0 asynchronously; the next transaction proceeds normally.
- Write to 0xA0, word address 0x10, data 0x5A,0xC3, STOP → three ACKs plus one for the address byte; then random read from 0x10 of 2 bytes returns 0x5A, 0xC3, with master NACK on the last byte.
- Address byte 0xA2 (wrong device) → no ACK; SDA never driven; busy_o high until STOP.
- Write at word address 0xFF, data 0x11,0x22 → mem[0xFF]=0x11, mem[0x00]=0x22. A current-address read after that returns mem[0x01] (0xFF when unwritten).
- Repeated START in the middle of a data byte during a write → partial byte discarded, memory unchanged, new device address byte ACKed.
- With I2C_EEPROM_WP_EN defined and wp_i=1: write 0x77 to 0x20 → data NACKed, and a read of 0x20 returns the prior value 0xFF.
